// File: rtl/i2c_master_tx.sv
`timescale 1ns/1ps
// i2c_master_tx: I2C write initiator. Sends START, one address byte, one data byte and STOP
// on open-drain SCL/SDA, checking the responder ACK after each byte. An address NACK skips
// the data byte and goes straight to STOP.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      synchronous active-low reset
//   start_i     single-cycle request, accepted only while busy_o is low
//   tx_addr_i   first byte on the bus, MSB first (R/W bit included)
//   tx_data_i   second byte on the bus, MSB first
//   busy_o      high from the cycle after accept until the done pulse
//   done_o      one-cycle pulse when the transaction (incl. STOP) completes
//   nack_o      1 = a byte of the last transaction was NACKed; updated with done, held
//   pin_scl_io  open-drain SCL (0 or z), never read
//   pin_sda_io  open-drain SDA (0 or z), read through a 3-flop synchronizer
module i2c_master_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] tx_addr_i,
  input  logic [7:0] tx_data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o,
  inout  wire        pin_scl_io,
  inout  wire        pin_sda_io
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StAddr, StAddrAck, StData, StDataAck, StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            nack_flag_q, nack_flag_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            nack_q, nack_d;
  logic            scl_low_q, sda_low_q;
  logic [2:0]      sda_sync_q;
  logic [1:0]      drv_d;
  logic            tick;

  // Returns {scl_low, sda_low} for a given state/quarter; b is the bit currently on SDA.
  function automatic logic [1:0] bus_drive(state_e st, logic [1:0] q, logic b);
    logic [1:0] r;
    r = 2'b00;
    case (st)
      StStart:              r = (q == 2'd2) ? 2'b01 : (q == 2'd3) ? 2'b11 : 2'b00;
      StAddr, StData:       r = {(q < 2'd2), ~b};
      StAddrAck, StDataAck: r = {(q < 2'd2), 1'b0};
      StStop:               r = (q == 2'd0) ? 2'b11 : (q == 2'd1) ? 2'b01 : 2'b00;
      default:              r = 2'b00;
    endcase
    return r;
  endfunction

  assign tick = (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    nack_flag_d = nack_flag_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    nack_d      = nack_q;

    // busy stays high through the done cycle so a start coinciding with done is ignored.
    if (done_q) busy_d = 1'b0;

    if (state_q == StIdle) begin
      if (start_i && !busy_q) begin
        state_d     = StStart;
        cnt_d       = '0;
        qtr_d       = 2'd0;
        bit_d       = 3'd7;
        shift_d     = tx_addr_i;
        data_d      = tx_data_i;
        nack_flag_d = 1'b0;
        busy_d      = 1'b1;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
      if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          case (state_q)
            StStart: state_d = StAddr;
            StAddr, StData: begin
              shift_d = {shift_q[6:0], 1'b0};
              bit_d   = bit_q - 3'd1;  // wraps back to 7 at byte end
              if (bit_q == 3'd0) state_d = (state_q == StAddr) ? StAddrAck : StDataAck;
            end
            StAddrAck: begin
              if (sda_sync_q[2]) begin
                nack_flag_d = 1'b1;
                state_d     = StStop;
              end else begin
                shift_d = data_q;
                state_d = StData;
              end
            end
            StDataAck: begin
              if (sda_sync_q[2]) nack_flag_d = 1'b1;
              state_d = StStop;
            end
            StStop: begin
              state_d = StIdle;
              done_d  = 1'b1;
              nack_d  = nack_flag_q;
            end
            default: state_d = StIdle;
          endcase
        end
      end
    end
  end

  // Pin drivers are registered from next-state so the open-drain outputs never glitch.
  assign drv_d = bus_drive(state_d, qtr_d, shift_d[7]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      qtr_q       <= 2'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      nack_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
      scl_low_q   <= 1'b0;
      sda_low_q   <= 1'b0;
      sda_sync_q  <= 3'b111;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      nack_flag_q <= nack_flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      nack_q      <= nack_d;
      scl_low_q   <= drv_d[1];
      sda_low_q   <= drv_d[0];
      sda_sync_q  <= {sda_sync_q[1:0], pin_sda_io};
    end
  end

  assign pin_scl_io = scl_low_q ? 1'b0 : 1'bz;
  assign pin_sda_io = sda_low_q ? 1'b0 : 1'bz;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign nack_o     = nack_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
`timescale 1ns/1ps
// Directed bench for i2c_master_tx with a behavioural responder and a bus-protocol monitor.
module tb_i2c_master_tx;

  localparam int unsigned ClkDiv = 4;
  localparam int FullLat = 1 + 80 * ClkDiv;  // 321
  localparam int NackLat = 1 + 44 * ClkDiv;  // 177

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_addr = 8'h00;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, nack;
  wire        scl_w, sda_w;
  logic       resp_low = 1'b0;

  pullup (scl_w);
  pullup (sda_w);
  assign sda_w = resp_low ? 1'b0 : 1'bz;

  int checks = 0;
  int failures = 0;

  // Monitor / responder state
  int         start_cnt, stop_cnt, viol, done_cnt, bitcnt, byte_idx, run;
  logic       scl_p, sda_p;
  logic [7:0] rx_sh;
  logic [7:0] rx_byte [2];
  logic       rx_ack [2];
  logic [1:0] ack_en = 2'b11;

  always #5 clk = ~clk;

  i2c_master_tx #(.CLK_DIV(ClkDiv)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .tx_addr_i  (tx_addr),
    .tx_data_i  (tx_data),
    .busy_o     (busy),
    .done_o     (done),
    .nack_o     (nack),
    .pin_scl_io (scl_w),
    .pin_sda_io (sda_w)
  );

  // Sampled mid-cycle: counts START/STOP, flags SDA activity and SCL phase lengths,
  // captures bytes at SCL rise and ACKs bytes enabled in ack_en.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (scl_w && scl_p && (sda_w != sda_p)) begin
      if (!sda_w) begin
        start_cnt++;
        bitcnt   = 0;
        byte_idx = 0;
      end else begin
        stop_cnt++;
      end
      resp_low = 1'b0;
    end
    if (scl_w != scl_p) begin
      if (scl_w) begin
        if (bitcnt >= 1 && bitcnt <= 8 && run != 2 * ClkDiv) viol++;
        if (bitcnt < 8) rx_sh = {rx_sh[6:0], sda_w};
        else if (byte_idx < 2) begin
          rx_byte[byte_idx] = rx_sh;
          rx_ack[byte_idx]  = sda_w;
        end
        bitcnt++;
      end else begin
        if (bitcnt >= 1 && run != 2 * ClkDiv) viol++;
        if (bitcnt == 8 && byte_idx < 2 && ack_en[byte_idx]) resp_low = 1'b1;
        else if (bitcnt == 9) begin
          resp_low = 1'b0;
          bitcnt   = 0;
          byte_idx++;
        end
      end
      run = 1;
    end else begin
      run++;
    end
    scl_p = scl_w;
    sda_p = sda_w;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    start_cnt  = 0;
    stop_cnt   = 0;
    viol       = 0;
    done_cnt   = 0;
    bitcnt     = 0;
    byte_idx   = 0;
    rx_byte[0] = 8'h00;
    rx_byte[1] = 8'h00;
    rx_ack[0]  = 1'b1;
    rx_ack[1]  = 1'b1;
    resp_low   = 1'b0;
    scl_p      = scl_w;
    sda_p      = sda_w;
    run        = 1;
  endtask

  // Called at #1 after an edge; returns at #1 after the accept edge.
  task automatic pulse_start(input logic [7:0] a, input logic [7:0] d);
    tx_addr = a;
    tx_data = d;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // lat = edges after the current one until done is seen; -1 on timeout.
  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic after_done(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_width"}, done, 1'b0);
    check({tag, "_busy_clear"}, busy, 1'b0);
  endtask

  task automatic check_bus(input string tag, input int starts, input int stops);
    check({tag, "_starts"}, start_cnt, starts);
    check({tag, "_stops"}, stop_cnt, stops);
    check({tag, "_timing_viol"}, viol, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    mon_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_nack", nack, 1'b0);
    check("rst_scl", scl_w, 1'b1);
    check("rst_sda", sda_w, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: ACKed write A4/5C
    mon_clear();
    ack_en = 2'b11;
    pulse_start(8'hA4, 8'h5C);
    check("t1_busy_after_accept", busy, 1'b1);
    wait_done(1000, lat);
    check("t1_done_cycle", lat + 1, FullLat);
    check("t1_nack", nack, 1'b0);
    check("t1_addr", rx_byte[0], 8'hA4);
    check("t1_data", rx_byte[1], 8'h5C);
    check("t1_ack0", rx_ack[0], 1'b0);
    check("t1_ack1", rx_ack[1], 1'b0);
    check_bus("t1", 1, 1);
    after_done("t1");

    // 2: responder absent, address NACK
    mon_clear();
    ack_en = 2'b00;
    pulse_start(8'h3C, 8'hE7);
    wait_done(1000, lat);
    check("t2_done_cycle", lat + 1, NackLat);
    check("t2_nack", nack, 1'b1);
    check("t2_addr", rx_byte[0], 8'h3C);
    check("t2_addr_ack", rx_ack[0], 1'b1);
    check("t2_bytes_sent", byte_idx, 1);
    check_bus("t2", 1, 1);
    after_done("t2");

    // 3: address ACKed, data NACKed
    mon_clear();
    ack_en = 2'b01;
    pulse_start(8'h52, 8'hC3);
    wait_done(1000, lat);
    check("t3_done_cycle", lat + 1, FullLat);
    check("t3_nack", nack, 1'b1);
    check("t3_addr", rx_byte[0], 8'h52);
    check("t3_data", rx_byte[1], 8'hC3);
    check("t3_data_ack", rx_ack[1], 1'b1);
    check_bus("t3", 1, 1);

    // 3b: start held from the done cycle: ignored there, accepted next cycle; nack clears
    mon_clear();
    ack_en  = 2'b11;
    tx_addr = 8'hA0;
    tx_data = 8'h0F;
    start   = 1'b1;
    @(posedge clk); #1;
    check("t3b_ignored_on_done", busy, 1'b0);
    check("t3b_nack_held", nack, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("t3b_accepted_next", busy, 1'b1);
    wait_done(1000, lat);
    check("t3b_done_cycle", lat + 1, FullLat);
    check("t3b_nack_cleared", nack, 1'b0);
    check("t3b_addr", rx_byte[0], 8'hA0);
    check("t3b_data", rx_byte[1], 8'h0F);
    check_bus("t3b", 1, 1);
    after_done("t3b");

    // 4: second start at N+50 is ignored
    mon_clear();
    ack_en = 2'b11;
    pulse_start(8'h6A, 8'h91);
    repeat (48) @(posedge clk);
    #1;
    tx_addr = 8'hFF;
    tx_data = 8'h00;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_busy_during", busy, 1'b1);
    wait_done(1000, lat);
    check("t4_done_cycle", 49 + lat + 1, FullLat);
    check("t4_addr", rx_byte[0], 8'h6A);
    check("t4_data", rx_byte[1], 8'h91);
    check_bus("t4", 1, 1);
    after_done("t4");

    // 5: one-cycle reset during the address byte
    mon_clear();
    pulse_start(8'h96, 8'h3A);
    repeat (32) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_scl_released", scl_w, 1'b1);
    check("t5_sda_released", sda_w, 1'b1);
    check("t5_busy", busy, 1'b0);
    mon_clear();
    repeat (400) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt, 0);
    check("t5_no_stop", stop_cnt, 0);
    check("t5_no_start", start_cnt, 0);
    mon_clear();
    pulse_start(8'h81, 8'h7E);
    wait_done(1000, lat);
    check("t5_fresh_done_cycle", lat + 1, FullLat);
    check("t5_fresh_nack", nack, 1'b0);
    check("t5_fresh_addr", rx_byte[0], 8'h81);
    check("t5_fresh_data", rx_byte[1], 8'h7E);
    check_bus("t5_fresh", 1, 1);
    after_done("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
